// File: rtl/elt_update.sv
// Element-table update engine: scans all cells for an open match and a free slot,
// then closes the matched version, overwrites it, or inserts a new element.
module elt_update #(
   parameter int NUM_CELLS = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [7:0] req_index,
   input  logic [7:0] req_value,
   input  logic [7:0] req_metadata,
   input  logic [7:0] req_rank,
   output logic [3:0] rd_addr,
   input  logic       rd_eltDef,
   input  logic [7:0] rd_index,
   input  logic [7:0] rd_rank,
   input  logic [7:0] rd_low,
   input  logic [7:0] rd_high,
   input  logic [7:0] rd_value,
   output logic       wr_en,
   output logic [3:0] wr_addr,
   output logic       wr_eltDef,
   output logic [7:0] wr_index,
   output logic [7:0] wr_rank,
   output logic [7:0] wr_low,
   output logic [7:0] wr_high,
   output logic [7:0] wr_value,
   output logic       resp_valid,
   output logic [1:0] resp_status,
   output logic [3:0] resp_slot
);

   localparam int CNT_W = $clog2(NUM_CELLS + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CELLS);
   localparam logic [7:0] OPEN = 8'hFF;
   localparam logic [1:0] ST_NEW   = 2'b00;
   localparam logic [1:0] ST_OVW   = 2'b01;
   localparam logic [1:0] ST_FULL  = 2'b10;
   localparam logic [1:0] ST_STALE = 2'b11;

   typedef enum logic [2:0] {IDLE, SCAN, DECIDE, CLOSE, WRITE, RESP} state_t;

   state_t           state_q, state_d;
   logic [1:0]       status_q, status_d;
   logic [3:0]       slot_q, slot_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       idx_q, idx_d, val_q, val_d, meta_q, meta_d, rank_q, rank_d;
   logic             hit_q, hit_d, free_q, free_d, ovw_q, ovw_d;
   logic [3:0]       hit_slot_q, hit_slot_d, free_slot_q, free_slot_d;
   logic [7:0]       hit_rank_q, hit_rank_d, hit_low_q, hit_low_d, hit_val_q, hit_val_d;
   logic [3:0]       eval_slot;

   // Read data lags the address by one cycle, so count N evaluates cell N-1.
   assign eval_slot = 4'(cnt_q - 1'b1);

   always_comb begin
      state_d     = state_q;
      status_d    = status_q;
      slot_d      = slot_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      val_d       = val_q;
      meta_d      = meta_q;
      rank_d      = rank_q;
      hit_d       = hit_q;
      free_d      = free_q;
      ovw_d       = ovw_q;
      hit_slot_d  = hit_slot_q;
      free_slot_d = free_slot_q;
      hit_rank_d  = hit_rank_q;
      hit_low_d   = hit_low_q;
      hit_val_d   = hit_val_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               idx_d   = req_index;
               val_d   = req_value;
               meta_d  = req_metadata;
               rank_d  = req_rank;
               cnt_d   = '0;
               hit_d   = 1'b0;
               free_d  = 1'b0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (cnt_q != '0) begin
               if (!rd_eltDef && !free_q) begin
                  free_d      = 1'b1;
                  free_slot_d = eval_slot;
               end
               if (rd_eltDef && rd_index == idx_q && rd_high == OPEN && !hit_q) begin
                  hit_d      = 1'b1;
                  hit_slot_d = eval_slot;
                  hit_rank_d = rd_rank;
                  hit_low_d  = rd_low;
                  hit_val_d  = rd_value;
               end
            end
            if (cnt_q == LAST) state_d = DECIDE;
            else               cnt_d   = cnt_q + 1'b1;
         end
         DECIDE: begin
            ovw_d    = 1'b0;
            slot_d   = 4'd0;
            status_d = ST_NEW;
            if (hit_q && hit_low_q == meta_q) begin
               ovw_d    = 1'b1;
               status_d = ST_OVW;
               slot_d   = hit_slot_q;
               state_d  = WRITE;
            end else if (hit_q && hit_low_q > meta_q) begin
               status_d = ST_STALE;
               state_d  = RESP;
            end else if (!free_q) begin
               status_d = ST_FULL;
               state_d  = RESP;
            end else begin
               slot_d  = free_slot_q;
               state_d = hit_q ? CLOSE : WRITE;
            end
         end
         CLOSE:   state_d = WRITE;
         WRITE:   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         status_q <= 2'b00;
         slot_q   <= 4'd0;
      end else begin
         state_q  <= state_d;
         status_q <= status_d;
         slot_q   <= slot_d;
      end
   end

   always_ff @(posedge clk) begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      val_q       <= val_d;
      meta_q      <= meta_d;
      rank_q      <= rank_d;
      hit_q       <= hit_d;
      free_q      <= free_d;
      ovw_q       <= ovw_d;
      hit_slot_q  <= hit_slot_d;
      free_slot_q <= free_slot_d;
      hit_rank_q  <= hit_rank_d;
      hit_low_q   <= hit_low_d;
      hit_val_q   <= hit_val_d;
   end

   assign rd_addr = (state_q == SCAN && cnt_q != LAST && !reset) ? 4'(cnt_q) : 4'd0;

   // Outputs are masked by reset so an aborted request cannot write or respond.
   always_comb begin
      req_ready   = 1'b0;
      wr_en       = 1'b0;
      wr_addr     = 4'd0;
      wr_eltDef   = 1'b0;
      wr_index    = 8'd0;
      wr_rank     = 8'd0;
      wr_low      = 8'd0;
      wr_high     = 8'd0;
      wr_value    = 8'd0;
      resp_valid  = 1'b0;
      resp_status = 2'b00;
      resp_slot   = 4'd0;
      if (!reset) begin
         case (state_q)
            IDLE: req_ready = 1'b1;
            CLOSE: begin
               wr_en     = 1'b1;
               wr_addr   = hit_slot_q;
               wr_eltDef = 1'b1;
               wr_index  = idx_q;
               wr_rank   = hit_rank_q;
               wr_low    = hit_low_q;
               wr_high   = meta_q - 8'd1;
               wr_value  = hit_val_q;
            end
            WRITE: begin
               wr_en     = 1'b1;
               wr_addr   = ovw_q ? hit_slot_q : free_slot_q;
               wr_eltDef = 1'b1;
               wr_index  = idx_q;
               wr_rank   = rank_q;
               wr_low    = ovw_q ? hit_low_q : meta_q;
               wr_high   = OPEN;
               wr_value  = val_q;
            end
            RESP: begin
               resp_valid  = 1'b1;
               resp_status = status_q;
               resp_slot   = slot_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_elt_update.sv
// Bench for elt_update: a cell memory with one-cycle read latency, fixed vectors,
// reset corner sequences and randomized requests against a table-level model.
module tb_elt_update;

   typedef struct packed {
      logic       def;
      logic [7:0] index;
      logic [7:0] rank;
      logic [7:0] low;
      logic [7:0] high;
      logic [7:0] value;
   } cell_t;

   typedef struct {
      int         nocc;
      cell_t      c0;
      logic [7:0] ri, rv, rm, rr;
      logic [1:0] st;
      logic [3:0] sl;
      int         lat;
      int         nwr;
      logic [3:0] aa;
      cell_t      ac;
      logic [3:0] ba;
      cell_t      bc;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_valid, req_ready;
   logic [7:0] req_index, req_value, req_metadata, req_rank;
   logic [3:0] rd_addr;
   logic       rd_eltDef;
   logic [7:0] rd_index, rd_rank, rd_low, rd_high, rd_value;
   logic       wr_en, wr_eltDef;
   logic [3:0] wr_addr;
   logic [7:0] wr_index, wr_rank, wr_low, wr_high, wr_value;
   logic       resp_valid;
   logic [1:0] resp_status;
   logic [3:0] resp_slot;

   logic       ld_en;
   logic [3:0] ld_addr;
   cell_t      ld_cell;
   cell_t      mem [16];
   cell_t      init_mem [16];
   cell_t      exp_mem [16];
   int unsigned wr_cnt = 0;
   int unsigned resp_cnt = 0;

   int checks = 0;
   int errors = 0;
   vec_t vt [9];

   always #5 clk = ~clk;

   elt_update #(.NUM_CELLS(16)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_index(req_index), .req_value(req_value),
      .req_metadata(req_metadata), .req_rank(req_rank),
      .rd_addr(rd_addr), .rd_eltDef(rd_eltDef),
      .rd_index(rd_index), .rd_rank(rd_rank), .rd_low(rd_low),
      .rd_high(rd_high), .rd_value(rd_value),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_eltDef(wr_eltDef),
      .wr_index(wr_index), .wr_rank(wr_rank), .wr_low(wr_low),
      .wr_high(wr_high), .wr_value(wr_value),
      .resp_valid(resp_valid), .resp_status(resp_status), .resp_slot(resp_slot)
   );

   // Cell memory: registered read, bench preload port has priority over DUT writes.
   always @(posedge clk) begin
      rd_eltDef <= mem[rd_addr].def;
      rd_index  <= mem[rd_addr].index;
      rd_rank   <= mem[rd_addr].rank;
      rd_low    <= mem[rd_addr].low;
      rd_high   <= mem[rd_addr].high;
      rd_value  <= mem[rd_addr].value;
      if (ld_en) mem[ld_addr] <= ld_cell;
      else if (wr_en) mem[wr_addr] <= {wr_eltDef, wr_index, wr_rank, wr_low, wr_high, wr_value};
      if (wr_en) wr_cnt <= wr_cnt + 1;
      if (resp_valid) resp_cnt <= resp_cnt + 1;
   end

   initial begin
      #900000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic cell_t mk(input logic d, input logic [7:0] ix, input logic [7:0] rk,
                                input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] va);
      cell_t c;
      c.def = d; c.index = ix; c.rank = rk; c.low = lo; c.high = hi; c.value = va;
      return c;
   endfunction

   function automatic cell_t filler(input int i);
      return mk(1'b1, 8'(160 + i), 8'(i), 8'(i), 8'h10, 8'(i));
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic check_cell(input string name, input cell_t act, input cell_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic load_mem();
      for (int i = 0; i < 16; i++) begin
         ld_en = 1'b1; ld_addr = 4'(i); ld_cell = init_mem[i];
         @(negedge clk);
      end
      ld_en = 1'b0;
      for (int i = 0; i < 16; i++) exp_mem[i] = init_mem[i];
   endtask

   task automatic start_req(input logic [7:0] idx, input logic [7:0] val, input logic [7:0] meta,
                            input logic [7:0] rank, input string tag);
      int g;
      g = 0;
      req_index = idx; req_value = val; req_metadata = meta; req_rank = rank;
      req_valid = 1'b1;
      while (!req_ready && g < 50) begin @(negedge clk); g++; end
      check({tag, "_hs_ready"}, 32'(req_ready), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic run_req(input logic [7:0] idx, input logic [7:0] val, input logic [7:0] meta,
                          input logic [7:0] rank, input bit junk, input string tag,
                          output int lat, output int nwr, output int nresp,
                          output logic [1:0] st, output logic [3:0] sl);
      int unsigned w0, r0;
      w0 = wr_cnt; r0 = resp_cnt;
      start_req(idx, val, meta, rank, tag);
      if (junk) begin
         req_index = 8'($urandom); req_value = 8'($urandom);
         req_metadata = 8'($urandom); req_rank = 8'($urandom);
      end else begin
         req_valid = 1'b0;
      end
      lat = 0; st = 2'b00; sl = 4'd0;
      while (lat < 60) begin
         @(negedge clk);
         lat++;
         if (resp_valid) begin st = resp_status; sl = resp_slot; break; end
      end
      req_valid = 1'b0;
      @(negedge clk);
      check({tag, "_pulse_end"}, 32'(resp_valid), 32'd0);
      check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
      nwr = int'(wr_cnt - w0);
      nresp = int'(resp_cnt - r0);
   endtask

   // Table-level model: locate lowest open match and lowest free cell, then apply the rules.
   task automatic model(input logic [7:0] idx, input logic [7:0] val, input logic [7:0] meta,
                        input logic [7:0] rank, output logic [1:0] st, output logic [3:0] sl,
                        output int lat, output int nwr);
      int m, f;
      m = -1; f = -1;
      for (int i = 0; i < 16; i++) begin
         if (m < 0 && exp_mem[i].def && exp_mem[i].index == idx && exp_mem[i].high == 8'hFF) m = i;
         if (f < 0 && !exp_mem[i].def) f = i;
      end
      sl = 4'd0; nwr = 0; lat = 16 + 3;
      if (m >= 0 && exp_mem[m].low == meta) begin
         exp_mem[m].value = val; exp_mem[m].rank = rank;
         st = 2'b01; sl = 4'(m); nwr = 1; lat = 16 + 4;
      end else if (m >= 0 && exp_mem[m].low > meta) begin
         st = 2'b11;
      end else if (f < 0) begin
         st = 2'b10;
      end else begin
         if (m >= 0) begin
            exp_mem[m].high = meta - 8'd1;
            nwr = 2; lat = 16 + 5;
         end else begin
            nwr = 1; lat = 16 + 4;
         end
         exp_mem[f] = mk(1'b1, idx, rank, meta, 8'hFF, val);
         st = 2'b00; sl = 4'(f);
      end
   endtask

   initial begin
      int lat, nwr, nresp, elat, enwr, bad;
      int unsigned w0, r0;
      logic [1:0] st, est;
      logic [3:0] sl, esl;
      bit full;
      string tag;

      vt[0] = '{0,  mk(0,0,0,0,0,0),                8'h05, 8'h22, 8'h03, 8'h11, 2'b00, 4'd0, 20, 1,
                4'd0,  mk(1,8'h05,8'h11,8'h03,8'hFF,8'h22), 4'd1, mk(0,0,0,0,0,0)};
      vt[1] = '{1,  mk(1,8'h05,8'h33,8'h03,8'hFF,8'h10), 8'h05, 8'h55, 8'h07, 8'h44, 2'b00, 4'd1, 21, 2,
                4'd0,  mk(1,8'h05,8'h33,8'h03,8'h06,8'h10), 4'd1, mk(1,8'h05,8'h44,8'h07,8'hFF,8'h55)};
      vt[2] = '{1,  mk(1,8'h05,8'h33,8'h07,8'hFF,8'h10), 8'h05, 8'h44, 8'h07, 8'h66, 2'b01, 4'd0, 20, 1,
                4'd0,  mk(1,8'h05,8'h66,8'h07,8'hFF,8'h44), 4'd1, mk(0,0,0,0,0,0)};
      vt[3] = '{1,  mk(1,8'h05,8'h33,8'h09,8'hFF,8'h10), 8'h05, 8'h77, 8'h04, 8'h01, 2'b11, 4'd0, 19, 0,
                4'd0,  mk(1,8'h05,8'h33,8'h09,8'hFF,8'h10), 4'd1, mk(0,0,0,0,0,0)};
      vt[4] = '{16, mk(1,8'h05,8'h33,8'h02,8'hFF,8'h10), 8'h05, 8'h88, 8'h05, 8'h02, 2'b10, 4'd0, 19, 0,
                4'd0,  mk(1,8'h05,8'h33,8'h02,8'hFF,8'h10), 4'd15, filler(15)};
      vt[5] = '{16, mk(1,8'h05,8'h33,8'h02,8'hFF,8'h10), 8'h09, 8'h88, 8'h05, 8'h02, 2'b10, 4'd0, 19, 0,
                4'd0,  mk(1,8'h05,8'h33,8'h02,8'hFF,8'h10), 4'd7, filler(7)};
      vt[6] = '{4,  mk(1,8'h05,8'h33,8'h02,8'h40,8'h10), 8'h05, 8'h99, 8'h08, 8'h03, 2'b00, 4'd4, 20, 1,
                4'd4,  mk(1,8'h05,8'h03,8'h08,8'hFF,8'h99), 4'd0, mk(1,8'h05,8'h33,8'h02,8'h40,8'h10)};
      vt[7] = '{1,  mk(1,8'h05,8'h33,8'h00,8'hFF,8'h10), 8'h05, 8'hAB, 8'h01, 8'h04, 2'b00, 4'd1, 21, 2,
                4'd0,  mk(1,8'h05,8'h33,8'h00,8'h00,8'h10), 4'd1, mk(1,8'h05,8'h04,8'h01,8'hFF,8'hAB)};
      vt[8] = '{1,  mk(1,8'h05,8'h33,8'hFF,8'hFF,8'h10), 8'h05, 8'hCD, 8'hFF, 8'h05, 2'b01, 4'd0, 20, 1,
                4'd0,  mk(1,8'h05,8'h05,8'hFF,8'hFF,8'hCD), 4'd1, mk(0,0,0,0,0,0)};

      reset = 1'b1; req_valid = 1'b0; ld_en = 1'b0; ld_addr = 4'd0; ld_cell = '0;
      req_index = 8'd0; req_value = 8'd0; req_metadata = 8'd0; req_rank = 8'd0;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_rd_addr", 32'(rd_addr), 32'd0);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_status_slot", 32'({resp_status, resp_slot}), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("rst_release_ready", 32'(req_ready), 32'd1);

      for (int v = 0; v < 9; v++) begin
         for (int i = 0; i < 16; i++)
            init_mem[i] = (i == 0) ? vt[v].c0 : ((i < vt[v].nocc) ? filler(i) : cell_t'(0));
         load_mem();
         tag = $sformatf("vec%0d", v);
         run_req(vt[v].ri, vt[v].rv, vt[v].rm, vt[v].rr, 1'b0, tag, lat, nwr, nresp, st, sl);
         check({tag, "_status"}, 32'(st), 32'(vt[v].st));
         check({tag, "_slot"}, 32'(sl), 32'(vt[v].sl));
         check({tag, "_latency"}, 32'(lat), 32'(vt[v].lat));
         check({tag, "_writes"}, 32'(nwr), 32'(vt[v].nwr));
         check({tag, "_resp_count"}, 32'(nresp), 32'd1);
         check_cell({tag, "_cellA"}, mem[vt[v].aa], vt[v].ac);
         check_cell({tag, "_cellB"}, mem[vt[v].ba], vt[v].bc);
      end

      // Reset during SCAN: request is dropped entirely.
      for (int i = 0; i < 16; i++) init_mem[i] = '0;
      load_mem();
      w0 = wr_cnt; r0 = resp_cnt;
      start_req(8'h05, 8'h22, 8'h03, 8'h11, "scanrst");
      req_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("scanrst_rd_addr", 32'(rd_addr), 32'd4);
      check("scanrst_busy_ready", 32'(req_ready), 32'd0);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("scanrst_hold_ready", 32'(req_ready), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("scanrst_ready_after", 32'(req_ready), 32'd1);
      repeat (30) @(negedge clk);
      check("scanrst_writes", wr_cnt - w0, 32'd0);
      check("scanrst_resps", resp_cnt - r0, 32'd0);
      check("scanrst_cell0_def", 32'(mem[0].def), 32'd0);

      // Reset in the WRITE cycle after a CLOSE: the close stays, the insert is lost.
      for (int i = 0; i < 16; i++) init_mem[i] = (i == 0) ? vt[1].c0 : cell_t'(0);
      load_mem();
      w0 = wr_cnt; r0 = resp_cnt;
      start_req(8'h05, 8'h55, 8'h07, 8'h44, "closerst");
      req_valid = 1'b0;
      repeat (19) @(negedge clk);
      check("closerst_close_en", 32'(wr_en), 32'd1);
      check("closerst_close_high", 32'({wr_addr, wr_high}), 32'h006);
      @(negedge clk);
      check("closerst_write_addr", 32'({wr_en, wr_addr}), 32'h11);
      reset = 1'b1;
      #1;
      check("closerst_masked", 32'(wr_en), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (25) @(negedge clk);
      check("closerst_writes", wr_cnt - w0, 32'd1);
      check("closerst_resps", resp_cnt - r0, 32'd0);
      check_cell("closerst_cell0", mem[0], mk(1,8'h05,8'h33,8'h03,8'h06,8'h10));
      check("closerst_cell1_def", 32'(mem[1].def), 32'd0);

      // Randomized requests, with junk requests held on the port while busy.
      for (int t = 0; t < 150; t++) begin
         full = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < 16; i++)
            init_mem[i] = mk(full ? 1'b1 : ($urandom_range(0, 2) != 0), 8'($urandom_range(0, 3)),
                             8'($urandom), 8'($urandom_range(0, 15)),
                             ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom_range(0, 254)),
                             8'($urandom));
         load_mem();
         req_index = 8'($urandom_range(0, 3));
         req_metadata = 8'($urandom_range(0, 15));
         req_value = 8'($urandom);
         req_rank = 8'($urandom);
         model(req_index, req_value, req_metadata, req_rank, est, esl, elat, enwr);
         tag = $sformatf("rnd%0d", t);
         run_req(req_index, req_value, req_metadata, req_rank, 1'($urandom_range(0, 1)), tag,
                 lat, nwr, nresp, st, sl);
         check({tag, "_status"}, 32'(st), 32'(est));
         check({tag, "_slot"}, 32'(sl), 32'(esl));
         check({tag, "_latency"}, 32'(lat), 32'(elat));
         check({tag, "_writes"}, 32'(nwr), 32'(enwr));
         bad = 0;
         for (int i = 0; i < 16; i++) if (mem[i] !== exp_mem[i]) bad++;
         check({tag, "_mem_cells_wrong"}, 32'(bad), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
